nios_accelerometer_spi_slave: RTL and testbench

NIOS_ACCELEROMETER_SPI_SLAVE -- requirements
Module: nios_accelerometer_spi_slave

---
 rtl/nios_accelerometer_spi_pkg.sv | 41 ++++
 rtl/nios_accelerometer_spi_sync_edge.sv | 33 +++
 rtl/nios_accelerometer_spi_slave.sv | 188 ++++++++++++++++++
 tb/tb_nios_accelerometer_spi_slave.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios_accelerometer_spi_pkg.sv
// Shared constants for the accelerometer SPI slave: register map,
// status/control bit positions and the default frame width.
package nios_accelerometer_spi_pkg;

  localparam int unsigned DATABITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    ADDR_RXDATA  = 3'd0,
    ADDR_TXDATA  = 3'd1,
    ADDR_STATUS  = 3'd2,
    ADDR_CONTROL = 3'd3
  } reg_addr_e;

  localparam int unsigned ST_TOE  = 2;
  localparam int unsigned ST_ROE  = 3;
  localparam int unsigned ST_TUR  = 4;
  localparam int unsigned ST_TRDY = 6;
  localparam int unsigned ST_RRDY = 7;
  localparam int unsigned ST_E    = 8;
  localparam int unsigned ST_SSA  = 9;

  // Interrupt-enable bits that exist in the control register.
  localparam logic [15:0] CTRL_MASK = 16'h01DC;

  function automatic logic [15:0] pack_status(
    input logic ssa, input logic e, input logic rrdy, input logic trdy,
    input logic tur, input logic roe, input logic toe
  );
    logic [15:0] s;
    s          = '0;
    s[ST_SSA]  = ssa;
    s[ST_E]    = e;
    s[ST_RRDY] = rrdy;
    s[ST_TRDY] = trdy;
    s[ST_TUR]  = tur;
    s[ST_ROE]  = roe;
    s[ST_TOE]  = toe;
    return s;
  endfunction

endpackage

// File: rtl/nios_accelerometer_spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module nios_accelerometer_spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchronizer and remember the last level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, async_i});
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/nios_accelerometer_spi_slave.sv
// CPU-mapped SPI slave (CPOL=0, CPHA=0, MSB first) sampling the SPI pins
// with the system clock.
module nios_accelerometer_spi_slave
  import nios_accelerometer_spi_pkg::*;
#(
  parameter int unsigned DATABITS    = DATABITS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  output logic        irq
);

  localparam int unsigned   CW       = (DATABITS > 1) ? $clog2(DATABITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATABITS - 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;
  logic wdata_unused;

  nios_accelerometer_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .async_i(SCLK),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  nios_accelerometer_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .async_i(SS_n),
    .level_o(ss_level), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  nios_accelerometer_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .async_i(MOSI),
    .level_o(mosi_level), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  assign wdata_unused = ^(data_from_cpu & ~CTRL_MASK);

  logic [DATABITS-1:0] rx_shift_q, rx_shift_d, rx_hold_q, rx_hold_d, rx_next;
  logic [DATABITS-1:0] tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
  logic [CW-1:0]       bitcnt_q, bitcnt_d;
  logic                primed_q, primed_d, rrdy_q, rrdy_d, roe_q, roe_d;
  logic                tur_q, tur_d, toe_q, toe_d, irq_q, irq_d;
  logic [15:0]         ctrl_q, ctrl_d, rdata_q, rdata_d, status;
  logic                rd_en, wr_en, trdy, err, ss_active, tx_load;

  assign rd_en     = spi_select & ~read_n;
  assign wr_en     = spi_select & ~write_n;
  assign trdy      = ~primed_q;
  assign err       = roe_q | tur_q | toe_q;
  assign ss_active = ~ss_level;
  assign rx_next   = {rx_shift_q[DATABITS-2:0], mosi_level};
  assign status    = pack_status(ss_active, err, rrdy_q, trdy, tur_q, roe_q, toe_q);

  // Next-state logic: CPU clears are applied first so SPI-side sets win.
  always_comb begin
    rx_shift_d = rx_shift_q;
    rx_hold_d  = rx_hold_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    bitcnt_d   = bitcnt_q;
    primed_d   = primed_q;
    rrdy_d     = rrdy_q;
    roe_d      = roe_q;
    tur_d      = tur_q;
    toe_d      = toe_q;
    ctrl_d     = ctrl_q;
    rdata_d    = rdata_q;
    tx_load    = 1'b0;

    if (rd_en) begin
      case (mem_addr)
        ADDR_RXDATA: begin
          rdata_d = 16'(rx_hold_q);
          rrdy_d  = 1'b0;
        end
        ADDR_STATUS:  rdata_d = status;
        ADDR_CONTROL: rdata_d = ctrl_q;
        default:      rdata_d = '0;
      endcase
    end

    if (wr_en) begin
      case (mem_addr)
        ADDR_TXDATA: begin
          if (trdy) begin
            tx_hold_d = data_from_cpu[DATABITS-1:0];
            primed_d  = 1'b1;
          end else begin
            toe_d = 1'b1;
          end
        end
        ADDR_STATUS: begin
          rrdy_d = 1'b0;
          roe_d  = 1'b0;
          tur_d  = 1'b0;
          toe_d  = 1'b0;
        end
        ADDR_CONTROL: ctrl_d = data_from_cpu & CTRL_MASK;
        default: ;
      endcase
    end

    // A falling SCLK with the counter at zero can only follow a completed
    // frame, since the first rise of a frame always moves it off zero.
    if (ss_fall) begin
      bitcnt_d = '0;
      tx_load  = 1'b1;
    end else if (ss_rise) begin
      bitcnt_d = '0;
    end else if (ss_active && sclk_rise) begin
      rx_shift_d = rx_next;
      if (bitcnt_q == LAST_BIT) begin
        rx_hold_d = rx_next;
        roe_d     = roe_d | rrdy_q;
        rrdy_d    = 1'b1;
        bitcnt_d  = '0;
      end else begin
        bitcnt_d = bitcnt_q + 1'b1;
      end
    end else if (ss_active && sclk_fall) begin
      if (bitcnt_q == '0) tx_load = 1'b1;
      else                tx_shift_d = {tx_shift_q[DATABITS-2:0], 1'b0};
    end

    if (tx_load) begin
      if (primed_q) begin
        tx_shift_d = tx_hold_q;
        primed_d   = 1'b0;
      end else begin
        tx_shift_d = '0;
        tur_d      = 1'b1;
      end
    end

    irq_d = (rrdy_q & ctrl_q[ST_RRDY]) | (trdy & ctrl_q[ST_TRDY]) |
            (roe_q & ctrl_q[ST_ROE]) | (tur_q & ctrl_q[ST_TUR]) |
            (toe_q & ctrl_q[ST_TOE]) | (err & ctrl_q[ST_E]);
  end

  // State register for all datapath, flag and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_shift_q <= '0;
      rx_hold_q  <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      bitcnt_q   <= '0;
      primed_q   <= 1'b0;
      rrdy_q     <= 1'b0;
      roe_q      <= 1'b0;
      tur_q      <= 1'b0;
      toe_q      <= 1'b0;
      ctrl_q     <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_hold_q  <= rx_hold_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      bitcnt_q   <= bitcnt_d;
      primed_q   <= primed_d;
      rrdy_q     <= rrdy_d;
      roe_q      <= roe_d;
      tur_q      <= tur_d;
      toe_q      <= toe_d;
      ctrl_q     <= ctrl_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign data_to_cpu = rdata_q;
  assign irq         = irq_q;
  assign MISO        = ss_active & tx_shift_q[DATABITS-1];
  assign MISO_oe     = ss_active;

endmodule

// File: tb/tb_nios_accelerometer_spi_slave.sv
// Self-checking bench: a frame-level reference model of the register file
// and SPI engine, driven by directed scenarios and a random operation mix.
module tb_nios_accelerometer_spi_slave;

  logic        clk = 1'b0;
  logic        reset, spi_select, read_n, write_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic        SCLK, SS_n, MOSI, MISO, MISO_oe, irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic       m_primed, m_rrdy, m_roe, m_tur, m_toe;
  logic [7:0] m_txhold, m_rx;
  logic [15:0] m_ctrl;

  nios_accelerometer_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_select(spi_select), .read_n(read_n),
    .write_n(write_n), .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_primed = 0; m_rrdy = 0; m_roe = 0; m_tur = 0; m_toe = 0;
    m_txhold = 0; m_rx = 0; m_ctrl = 0;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s = 16'h0000;
    s[8] = m_roe | m_tur | m_toe;
    s[7] = m_rrdy;
    s[6] = ~m_primed;
    s[4] = m_tur;
    s[3] = m_roe;
    s[2] = m_toe;
    return s;
  endfunction

  function automatic logic m_irq();
    return (m_rrdy & m_ctrl[7]) | (~m_primed & m_ctrl[6]) | (m_roe & m_ctrl[3]) |
           (m_tur & m_ctrl[4]) | (m_toe & m_ctrl[2]) |
           ((m_roe | m_tur | m_toe) & m_ctrl[8]);
  endfunction

  // What the transmitter takes when a frame begins or a frame completes.
  task automatic m_load(output logic [7:0] w);
    if (m_primed) begin
      w = m_txhold;
      m_primed = 0;
    end else begin
      w = 8'h00;
      m_tur = 1;
    end
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    spi_select = 1; read_n = 0; mem_addr = a;
    @(negedge clk);
    spi_select = 0; read_n = 1;
    d = data_to_cpu;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
    @(negedge clk);
    spi_select = 0; write_n = 1;
    case (a)
      3'd1: if (!m_primed) begin m_txhold = d[7:0]; m_primed = 1; end else m_toe = 1;
      3'd2: begin m_rrdy = 0; m_roe = 0; m_tur = 0; m_toe = 0; end
      3'd3: m_ctrl = d & 16'h01DC;
      default: ;
    endcase
  endtask

  task automatic read_rx();
    logic [15:0] d;
    cpu_read(3'd0, d);
    check_eq("rx_data", d, {8'h00, m_rx});
    m_rrdy = 0;
  endtask

  task automatic check_state(input string tag);
    logic [15:0] d;
    repeat (2) @(negedge clk);
    check_eq({tag, "_irq"}, 16'(irq), 16'(m_irq()));
    cpu_read(3'd2, d);
    check_eq({tag, "_status"}, d, m_status());
  endtask

  // SPI master at clk/8: SCLK low 4 clk, high 4 clk, MISO sampled before each rise.
  task automatic spi_xfer(input logic [7:0] mo, input int unsigned nbits, output logic [7:0] mi);
    mi = 8'h00;
    SS_n = 0;
    repeat (8) @(negedge clk);
    for (int unsigned i = 0; i < nbits; i++) begin
      MOSI = mo[7-i];
      repeat (4) @(negedge clk);
      mi[7-i] = MISO;
      if (i == 0) check_eq("miso_oe", 16'(MISO_oe), 16'h0001);
      SCLK = 1;
      repeat (4) @(negedge clk);
      SCLK = 0;
    end
    repeat (6) @(negedge clk);
    SS_n = 1;
    MOSI = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_frame(input logic [7:0] mo, input int unsigned nbits);
    logic [7:0] exp_tx, got, mask, dummy;
    m_load(exp_tx);
    spi_xfer(mo, nbits, got);
    mask = 8'hFF << (8 - nbits);
    check_eq("miso_bits", 16'(got & mask), 16'(exp_tx & mask));
    if (nbits == 8) begin
      m_roe  = m_roe | m_rrdy;
      m_rrdy = 1;
      m_rx   = mo;
      m_load(dummy);
    end
  endtask

  initial begin
    logic [15:0] d;
    reset = 1; spi_select = 0; read_n = 1; write_n = 1; mem_addr = 0;
    data_from_cpu = 0; SCLK = 0; SS_n = 1; MOSI = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_dout", data_to_cpu, 16'h0000);
    check_eq("rst_pins", {13'h0, irq, MISO, MISO_oe}, 16'h0000);
    reset = 0;
    @(negedge clk);
    check_state("reset");
    cpu_read(3'd3, d); check_eq("ctrl_reset", d, 16'h0000);

    // Primed byte goes out while the master's byte comes in.
    cpu_write(3'd1, 16'h00A5);
    do_frame(8'h3C, 8);
    check_state("basic");
    read_rx();
    check_state("after_rx_read");
    cpu_read(3'd1, d); check_eq("addr1_reads0", d, 16'h0000);
    cpu_read(3'd5, d); check_eq("addr5_reads0", d, 16'h0000);

    // Underrun with its interrupt enabled.
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd3, 16'h0010);
    do_frame(8'h5A, 8);
    check_state("underrun");

    // Overrun: two frames without a read, then clear.
    cpu_write(3'd3, 16'h0008);
    cpu_write(3'd2, 16'h0000);
    do_frame(8'h11, 8);
    do_frame(8'h22, 8);
    check_state("overrun");
    read_rx();
    cpu_write(3'd2, 16'hFFFF);
    cpu_read(3'd2, d); check_eq("status_cleared_lo", {8'h00, d[7:0]}, 16'h0040);

    // Second tx write while primed is dropped.
    cpu_write(3'd1, 16'h0001);
    cpu_write(3'd1, 16'h0002);
    check_state("tx_overrun");
    do_frame(8'h00, 8);
    read_rx();

    // Aborted partial frame followed by a full one.
    cpu_write(3'd2, 16'h0000);
    do_frame(8'hF0, 5);
    check_state("partial");
    do_frame(8'h81, 8);
    check_state("after_partial");
    read_rx();

    // Random operation mix.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: cpu_write(3'd1, 16'($urandom));
        1: do_frame(8'($urandom), 8);
        2: do_frame(8'($urandom), $urandom_range(1, 7));
        3: read_rx();
        4: cpu_write(3'd2, 16'($urandom));
        default: cpu_write(3'd3, 16'($urandom));
      endcase
      check_state("random");
    end

    // Reset in the middle of a frame.
    SS_n = 0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'(i);
      repeat (4) @(negedge clk);
      SCLK = 1;
      repeat (4) @(negedge clk);
      SCLK = 0;
    end
    reset = 1;
    #1;
    check_eq("midrst_dout", data_to_cpu, 16'h0000);
    check_eq("midrst_pins", {13'h0, irq, MISO, MISO_oe}, 16'h0000);
    SS_n = 1; MOSI = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    m_reset();
    repeat (4) @(negedge clk);
    check_state("post_reset");
    do_frame(8'hC3, 8);
    check_state("post_reset_frame");
    read_rx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
